// File: rtl/fft_out_stream_if.sv
// fft_out_stream_if: upstream pair strobe plus downstream valid/ready sample stream.
// The master modport is the converter; the slave modport is its environment.
interface fft_out_stream_if #(
    parameter int WIDTH = 24
);
    logic               i_clk_enable;
    logic [2*WIDTH-1:0] i_in_0;
    logic [2*WIDTH-1:0] i_in_1;
    logic               i_sync;
    logic               o_valid;
    logic               i_ready;
    logic [2*WIDTH-1:0] o_data;
    logic               o_first;
    logic               o_last;
    logic               o_overflow;
    logic               o_frame_err;

    modport master (
        input  i_clk_enable, i_in_0, i_in_1, i_sync, i_ready,
        output o_valid, o_data, o_first, o_last, o_overflow, o_frame_err
    );

    modport slave (
        output i_clk_enable, i_in_0, i_in_1, i_sync, i_ready,
        input  o_valid, o_data, o_first, o_last, o_overflow, o_frame_err
    );
endinterface

// File: rtl/fft_out_stream.sv
// fft_out_stream: two-sample-per-enable FFT output to a one-sample valid/ready stream with frame markers.
// A pair FIFO absorbs back-pressure; a full FIFO drops pairs and unlocks until the next sync pair.
module fft_out_stream #(
    parameter int LGSIZE = 12,
    parameter int WIDTH  = 24,
    parameter int LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    fft_out_stream_if.master  bus
);
    localparam int SW = 2 * WIDTH;

    typedef enum logic [1:0] {EMPTY, S0, S1} state_t;

    state_t              state, state_n;
    logic [2*SW:0]       mem [1 << LGFIFO];
    logic [2*SW:0]       head;
    logic [LGFIFO-1:0]   wr_ptr, rd_ptr;
    logic [LGFIFO:0]     count;
    logic [SW-1:0]       hold;
    logic [LGSIZE-1:0]   cnt;
    logic                locked, full, empty, take, wr, drop, xfer, pop;

    // occupancy never exceeds the depth, so its MSB alone flags full
    assign full  = count[LGFIFO];
    assign empty = count == '0;
    assign take  = bus.i_clk_enable && (locked || bus.i_sync);
    assign wr    = take && !full;
    assign drop  = take && full;
    assign head  = mem[rd_ptr];
    assign xfer  = bus.o_valid && bus.i_ready;

    assign bus.o_valid = state != EMPTY;
    assign bus.o_last  = bus.o_valid && cnt == '1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state <= EMPTY;
        else
            state <= state_n;
    end

    always_comb begin
        pop     = 1'b0;
        state_n = state;
        pop     = !empty && (state == EMPTY || (state == S1 && xfer));
        state_n = state == EMPTY ? (pop ? S0 : EMPTY) :
                  !xfer          ? state :
                  state == S0    ? S1 :
                  pop            ? S0 : EMPTY;
    end

    always_ff @(posedge i_clk) begin
        if (wr)
            mem[wr_ptr] <= {bus.i_sync, bus.i_in_1, bus.i_in_0};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            locked          <= 1'b0;
            hold            <= '0;
            cnt             <= '0;
            bus.o_data      <= '0;
            bus.o_first     <= 1'b0;
            bus.o_overflow  <= 1'b0;
            bus.o_frame_err <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (LGFIFO+1)'(wr) - (LGFIFO+1)'(pop);
            if (drop) begin
                bus.o_overflow <= 1'b1;
                locked         <= 1'b0;
            end else if (wr && bus.i_sync) begin
                locked <= 1'b1;
            end
            if (pop) begin
                bus.o_data  <= head[SW-1:0];
                hold        <= head[2*SW-1:SW];
                bus.o_first <= head[2*SW];
            end else if (xfer && state == S0) begin
                bus.o_data  <= hold;
                bus.o_first <= 1'b0;
            end
            bus.o_frame_err <= xfer && bus.o_first && cnt != '0;
            if (xfer)
                cnt <= bus.o_first ? LGSIZE'(1) : cnt + 1'b1;
        end
    end
endmodule
